instr_encoder: RTL and testbench
================================

# instr_encoder

Pipelined RV64IM instruction encoder: accepts one instruction per handshake as a mnemonic code plus register and immediate fields, range-checks the fields, builds the 32-bit machine word, and packs two consecutive legal words into the 64-bit fetch word consumed by the instruction decoder (`instr[31:0]` first, `instr[63:32]` second). It sits between the test/stimulus generator and instruction memory, producing decoder-compatible streams.

## Interface
- ENC_NOP, 32'h0000_0013, padding word (ADDI x0,x0,0) for odd-length flushes
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept this cycle
- in_op  in  6  mnemonic: 0-9 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; 10-17 MUL MULH MULHSU MULHU DIV DIVU REM REMU; 18-27 ADDW SUBW SLLW SRLW SRAW MULW DIVW DIVUW REMW REMUW; 28-36 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; 37-40 ADDIW SLLIW SRLIW SRAIW; 41-47 LB LH LW LD LBU LHU LWU; 48-51 SB SH SW SD; 52-57 BEQ BNE BLT BGE BLTU BGEU; 58-61 LUI AUIPC JAL JALR; 62-63 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices (ignored where format has none)
- in_imm  in  32  signed immediate / offset / shamt
- in_last  in  1  flush: emit the pending half-word padded with ENC_NOP
- out_valid  out  1  64-bit word valid
- out_ready  in  1  consumer accepts
- out_data  out  64  packed word, first instruction in [31:0]
- out_half  out  1  upper half is ENC_NOP padding
- err  out  1  one-cycle pulse: an accepted request was illegal
- err_cnt  out  16  saturating count of illegal requests

## Operation
- Global advance enable en = !out_valid || out_ready; in_ready = en. All stages move only when en=1.
- Stage E (encode register): on accept, registers word, legal flag, last flag. Formats: R (funct7,rs2,rs1,funct3,rd,opcode), I, S, B, U, J per RV64IM; W ops use opcodes 0x3B/0x1B, loads 0x03, stores 0x23, branches 0x63, LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67.
- Legality: I/S/JALR imm in [-2048,2047]; SLLI/SRLI/SRAI shamt 0-63; W shifts 0-31; B imm in [-4096,4094] and even; JAL imm in [-2^20, 2^20-2] and even; LUI/AUIPC imm[11:0]==0, bits [31:12] placed directly; op 62/63 illegal. SRAI/SRAIW set bit 30.
- Illegal entry: dropped (never packed), err pulses the cycle it leaves E, err_cnt increments, saturates at 16'hFFFF. Its in_last flag still applies.
- Packer FSM, states EMPTY, HALF (holds low word):
  - EMPTY + legal, !last -> HALF.
  - EMPTY + legal, last -> load output {ENC_NOP, w}, out_half=1, stay EMPTY.
  - HALF + legal -> load output {w, low}, out_half=0 -> EMPTY.
  - HALF + illegal/none with last -> load {ENC_NOP, low}, out_half=1 -> EMPTY.
  - EMPTY + last with nothing pending -> no output.
- Output register holds data stable while out_valid && !out_ready.

## Timing
- Reset: in_ready=1, out_valid=0, out_data=0, out_half=0, err=0, err_cnt=0, FSM=EMPTY, E stage empty. Reset mid-operation discards pending half and output word.
- Latency: completing instruction accepted cycle N -> out_valid at N+2 with no backpressure.
- Throughput: one request per cycle, one 64-bit word per two instructions.
- out_ready low: in_ready drops same cycle (combinational); nothing lost or duplicated.

## Test plan
- After reset: ADD x1,x2,x3 (op 0) then ADDI x5,x0,-1 (op 28) back-to-back -> out_data=64'hFFF00293_003100B3, out_half=0, out_valid 2 cycles after second accept.
- ADD x1,x2,x3 with in_last=1 -> out_data=64'h00000013_003100B3, out_half=1.
- SRAI x1,x1,63 + JAL x1,2048 -> low word 32'h43F0D093, high 32'h001000EF.
- BEQ imm=3, SRAIW shamt 32, op 63 -> three err pulses, err_cnt=3, no out_valid.
- Hold out_ready=0 for 5 cycles with 6 requests offered -> in_ready=0 while stalled, all 3 words delivered in order unchanged.
- Accept one legal ADD (FSM=HALF), assert reset -> out_valid stays 0; subsequent pair packs from EMPTY.

Source files
------------

// File: rtl/instr_encoder.sv
// RV64IM instruction encoder: validates one request per handshake, builds the
// 32-bit machine word, and packs consecutive legal words into 64-bit fetch
// words (first instruction in [31:0]).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Valid never waits for ready. in_ready does not depend on in_valid. Once
// out_valid is high, out_data/out_half stay stable until out_ready is seen.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_half,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic        pack_state
);

  localparam logic [31:0] ENC_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_t;

  logic        en;
  fmt_t        fmt;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] i_field;
  logic        ok;
  logic [31:0] enc_word;
  logic        fits12, fits_b, fits_j, sh6, sh5;

  logic        e_valid, e_legal, e_last;
  logic [31:0] e_word;
  pack_t       state;
  logic [31:0] low;

  // Whole pipeline advances together whenever the output slot can move.
  assign en         = !out_valid || out_ready;
  assign in_ready   = en;
  assign pack_state = state;

  assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
  assign fits_b = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign fits_j = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
  assign sh6    = (in_imm[31:6] == 26'd0);
  assign sh5    = (in_imm[31:5] == 27'd0);

  // Mnemonic decode: format, opcode, funct fields and immediate legality.
  always_comb begin
    fmt     = FMT_R;
    opcode  = 7'h33;
    f3      = 3'd0;
    f7      = 7'h00;
    ok      = 1'b1;
    i_field = in_imm[11:0];
    case (in_op)
      6'd0:  f3 = 3'd0;
      6'd1:  f7 = 7'h20;
      6'd2:  f3 = 3'd1;
      6'd3:  f3 = 3'd2;
      6'd4:  f3 = 3'd3;
      6'd5:  f3 = 3'd4;
      6'd6:  f3 = 3'd5;
      6'd7:  begin f3 = 3'd5; f7 = 7'h20; end
      6'd8:  f3 = 3'd6;
      6'd9:  f3 = 3'd7;
      6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17: begin
        f7 = 7'h01;
        f3 = 3'(in_op - 6'd10);
      end
      6'd18: opcode = 7'h3B;
      6'd19: begin opcode = 7'h3B; f7 = 7'h20; end
      6'd20: begin opcode = 7'h3B; f3 = 3'd1; end
      6'd21: begin opcode = 7'h3B; f3 = 3'd5; end
      6'd22: begin opcode = 7'h3B; f3 = 3'd5; f7 = 7'h20; end
      6'd23: begin opcode = 7'h3B; f7 = 7'h01; end
      6'd24: begin opcode = 7'h3B; f7 = 7'h01; f3 = 3'd4; end
      6'd25: begin opcode = 7'h3B; f7 = 7'h01; f3 = 3'd5; end
      6'd26: begin opcode = 7'h3B; f7 = 7'h01; f3 = 3'd6; end
      6'd27: begin opcode = 7'h3B; f7 = 7'h01; f3 = 3'd7; end
      6'd28: begin fmt = FMT_I; opcode = 7'h13; ok = fits12; end
      6'd29: begin fmt = FMT_I; opcode = 7'h13; f3 = 3'd2; ok = fits12; end
      6'd30: begin fmt = FMT_I; opcode = 7'h13; f3 = 3'd3; ok = fits12; end
      6'd31: begin fmt = FMT_I; opcode = 7'h13; f3 = 3'd4; ok = fits12; end
      6'd32: begin fmt = FMT_I; opcode = 7'h13; f3 = 3'd6; ok = fits12; end
      6'd33: begin fmt = FMT_I; opcode = 7'h13; f3 = 3'd7; ok = fits12; end
      6'd34, 6'd35, 6'd36: begin
        fmt     = FMT_I;
        opcode  = 7'h13;
        f3      = (in_op == 6'd34) ? 3'd1 : 3'd5;
        ok      = sh6;
        i_field = {1'b0, (in_op == 6'd36), 4'b0, in_imm[5:0]};
      end
      6'd37: begin fmt = FMT_I; opcode = 7'h1B; ok = fits12; end
      6'd38, 6'd39, 6'd40: begin
        fmt     = FMT_I;
        opcode  = 7'h1B;
        f3      = (in_op == 6'd38) ? 3'd1 : 3'd5;
        ok      = sh5;
        i_field = {1'b0, (in_op == 6'd40), 5'b0, in_imm[4:0]};
      end
      6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47: begin
        fmt = FMT_I; opcode = 7'h03; f3 = 3'(in_op - 6'd41); ok = fits12;
      end
      6'd48, 6'd49, 6'd50, 6'd51: begin
        fmt = FMT_S; opcode = 7'h23; f3 = in_op[2:0]; ok = fits12;
      end
      6'd52: begin fmt = FMT_B; opcode = 7'h63; f3 = 3'd0; ok = fits_b; end
      6'd53: begin fmt = FMT_B; opcode = 7'h63; f3 = 3'd1; ok = fits_b; end
      6'd54: begin fmt = FMT_B; opcode = 7'h63; f3 = 3'd4; ok = fits_b; end
      6'd55: begin fmt = FMT_B; opcode = 7'h63; f3 = 3'd5; ok = fits_b; end
      6'd56: begin fmt = FMT_B; opcode = 7'h63; f3 = 3'd6; ok = fits_b; end
      6'd57: begin fmt = FMT_B; opcode = 7'h63; f3 = 3'd7; ok = fits_b; end
      6'd58: begin fmt = FMT_U; opcode = 7'h37; ok = (in_imm[11:0] == 12'd0); end
      6'd59: begin fmt = FMT_U; opcode = 7'h17; ok = (in_imm[11:0] == 12'd0); end
      6'd60: begin fmt = FMT_J; opcode = 7'h6F; ok = fits_j; end
      6'd61: begin fmt = FMT_I; opcode = 7'h67; ok = fits12; end
      default: ok = 1'b0;
    endcase
  end

  // Field placement per instruction format.
  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_R: enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opcode};
      FMT_I: enc_word = {i_field, in_rs1, f3, in_rd, opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                         in_imm[4:1], in_imm[11], opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, opcode};
      default: enc_word = 32'd0;
    endcase
  end

  // Stage E: capture the encoded word on accept; empties on an idle advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_legal <= 1'b0;
      e_last  <= 1'b0;
      e_word  <= 32'd0;
    end else if (en) begin
      e_valid <= in_valid;
      if (in_valid) begin
        e_legal <= ok;
        e_last  <= in_last;
        e_word  <= enc_word;
      end
    end
  end

  // Packer FSM, output register and illegal-request accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      low       <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
      out_half  <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 16'd0;
    end else begin
      err <= en && e_valid && !e_legal;
      if (en && e_valid && !e_legal && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if (en) begin
        out_valid <= 1'b0;
        if (e_valid) begin
          case (state)
            EMPTY: begin
              if (e_legal && e_last) begin
                out_valid <= 1'b1;
                out_data  <= {ENC_NOP, e_word};
                out_half  <= 1'b1;
              end else if (e_legal) begin
                low   <= e_word;
                state <= HALF;
              end
            end
            HALF: begin
              if (e_legal) begin
                out_valid <= 1'b1;
                out_data  <= {e_word, low};
                out_half  <= 1'b0;
                state     <= EMPTY;
              end else if (e_last) begin
                out_valid <= 1'b1;
                out_data  <= {ENC_NOP, low};
                out_half  <= 1'b1;
                state     <= EMPTY;
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written multi-cycle
// sequences (pairing, flush, stall, reset-while-half) and a randomized run
// checked against an arithmetic reference model.
module tb_instr_encoder;

  localparam logic [31:0] ENC_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_half;
  logic        err;
  logic [15:0] err_cnt;
  logic        pack_state;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_half(out_half),
    .err(err), .err_cnt(err_cnt), .pack_state(pack_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int ill_total = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back({out_half, out_data});
      if (err) err_seen++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_queues(input string name);
    logic [64:0] g, e;
    chk({name, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({name, " data"}, g[63:0], e[63:0]);
      chk({name, " half"}, {63'd0, g[64]}, {63'd0, e[64]});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- reference model ----------------
  int r_f3 [0:27] = '{0,0,1,2,3,4,5,5,6,7, 0,1,2,3,4,5,6,7, 0,0,1,5,5,0,4,5,6,7};
  int r_f7 [0:27] = '{0,32,0,0,0,0,0,32,0,0, 1,1,1,1,1,1,1,1, 0,32,0,0,32,1,1,1,1,1};
  int i_f3 [0:8]  = '{0,2,3,4,6,7,1,5,5};
  int iw_f3 [0:3] = '{0,1,5,5};
  int b_f3 [0:5]  = '{0,1,4,5,6,7};

  // Returns {legal, word} computed from the instruction set rules.
  function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1,
                                          input int rs2, input logic [31:0] imm_b);
    int imm;
    longint acc, u;
    bit legal;
    bit in12;
    imm = int'(imm_b);
    in12 = (imm >= -2048) && (imm <= 2047);
    acc = 0;
    legal = 1'b1;
    if (op <= 27) begin
      acc = longint'(r_f7[op]) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
          + r_f3[op] * (1 << 12) + rd * 128 + ((op < 18) ? 51 : 59);
    end else if (op <= 36) begin
      if (op >= 34) begin
        legal = (imm >= 0) && (imm <= 63);
        u = imm + ((op == 36) ? 1024 : 0);
      end else begin
        legal = in12;
        u = imm & 4095;
      end
      acc = u * (1 << 20) + rs1 * (1 << 15) + i_f3[op-28] * (1 << 12) + rd * 128 + 19;
    end else if (op <= 40) begin
      if (op >= 38) begin
        legal = (imm >= 0) && (imm <= 31);
        u = imm + ((op == 40) ? 1024 : 0);
      end else begin
        legal = in12;
        u = imm & 4095;
      end
      acc = u * (1 << 20) + rs1 * (1 << 15) + iw_f3[op-37] * (1 << 12) + rd * 128 + 27;
    end else if (op <= 47) begin
      legal = in12;
      acc = longint'(imm & 4095) * (1 << 20) + rs1 * (1 << 15) + (op - 41) * (1 << 12)
          + rd * 128 + 3;
    end else if (op <= 51) begin
      legal = in12;
      u = imm & 4095;
      acc = (u / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
          + (op - 48) * (1 << 12) + (u % 32) * 128 + 35;
    end else if (op <= 57) begin
      legal = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
      u = imm & 8191;
      acc = (u / 4096) * (longint'(1) << 31) + ((u / 32) % 64) * (1 << 25)
          + rs2 * (1 << 20) + rs1 * (1 << 15) + b_f3[op-52] * (1 << 12)
          + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + 99;
    end else if (op <= 59) begin
      legal = ((imm & 4095) == 0);
      acc = longint'({32'd0, imm_b}) + rd * 128 + ((op == 58) ? 55 : 23);
    end else if (op == 60) begin
      legal = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
      u = imm & 2097151;
      acc = (u / 1048576) * (longint'(1) << 31) + ((u / 2) % 1024) * (1 << 21)
          + ((u / 2048) % 2) * (1 << 20) + ((u / 4096) % 256) * (1 << 12)
          + rd * 128 + 111;
    end else if (op == 61) begin
      legal = in12;
      acc = longint'(imm & 4095) * (1 << 20) + rs1 * (1 << 15) + rd * 128 + 103;
    end else begin
      legal = 1'b0;
    end
    return {legal, 32'(acc)};
  endfunction

  bit          m_pend = 1'b0;
  logic [31:0] m_low;
  int          m_ill = 0;

  task automatic model_accept(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    logic [32:0] r;
    r = ref_enc(int'(op), int'(rd), int'(rs1), int'(rs2), imm);
    if (r[32]) begin
      if (m_pend) begin
        exp_q.push_back({1'b0, r[31:0], m_low});
        m_pend = 1'b0;
      end else if (last) begin
        exp_q.push_back({1'b1, ENC_NOP, r[31:0]});
      end else begin
        m_low  = r[31:0];
        m_pend = 1'b1;
      end
    end else begin
      m_ill++;
      ill_total++;
      if (last && m_pend) begin
        exp_q.push_back({1'b1, ENC_NOP, m_low});
        m_pend = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL send timeout: in_ready stayed 0 for op %0d", op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic legal,
                         input logic [31:0] word);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.legal = legal; v.word = word;
    vecs.push_back(v);
  endtask

  bit rnd_on = 1'b0;

  initial begin
    int eb;
    logic [63:0] held;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; in_op = 6'd0; in_rd = 5'd0; in_rs1 = 5'd0;
    in_rs2 = 5'd0; in_imm = 32'd0; in_last = 1'b0; out_ready = 1'b1;

    add_vec(6'd0,  5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h003100B3);
    add_vec(6'd1,  5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h403100B3);
    add_vec(6'd10, 5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h023100B3);
    add_vec(6'd18, 5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h003100BB);
    add_vec(6'd28, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF,   1'b1, 32'hFFF00293);
    add_vec(6'd28, 5'd0, 5'd0, 5'd0, 32'd2047,       1'b1, 32'h7FF00013);
    add_vec(6'd28, 5'd0, 5'd0, 5'd0, 32'd2048,       1'b0, 32'h0);
    add_vec(6'd28, 5'd0, 5'd0, 5'd0, 32'hFFFFF800,   1'b1, 32'h80000013);
    add_vec(6'd28, 5'd0, 5'd0, 5'd0, 32'hFFFFF7FF,   1'b0, 32'h0);
    add_vec(6'd36, 5'd1, 5'd1, 5'd0, 32'd63,         1'b1, 32'h43F0D093);
    add_vec(6'd34, 5'd1, 5'd1, 5'd0, 32'd64,         1'b0, 32'h0);
    add_vec(6'd40, 5'd1, 5'd1, 5'd0, 32'd31,         1'b1, 32'h41F0D09B);
    add_vec(6'd40, 5'd1, 5'd1, 5'd0, 32'd32,         1'b0, 32'h0);
    add_vec(6'd44, 5'd1, 5'd2, 5'd0, 32'd0,          1'b1, 32'h00013083);
    add_vec(6'd51, 5'd0, 5'd1, 5'd2, 32'd8,          1'b1, 32'h0020B423);
    add_vec(6'd52, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1'b1, 32'hFE208EE3);
    add_vec(6'd52, 5'd0, 5'd0, 5'd0, 32'd3,          1'b0, 32'h0);
    add_vec(6'd55, 5'd0, 5'd0, 5'd0, 32'd4094,       1'b1, 32'h7E005FE3);
    add_vec(6'd55, 5'd0, 5'd0, 5'd0, 32'd4096,       1'b0, 32'h0);
    add_vec(6'd58, 5'd1, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123450B7);
    add_vec(6'd58, 5'd1, 5'd0, 5'd0, 32'h00000800,   1'b0, 32'h0);
    add_vec(6'd59, 5'd1, 5'd0, 5'd0, 32'hFFFFF000,   1'b1, 32'hFFFFF097);
    add_vec(6'd60, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, 32'h001000EF);
    add_vec(6'd60, 5'd1, 5'd0, 5'd0, 32'hFFF00000,   1'b1, 32'h800000EF);
    add_vec(6'd60, 5'd1, 5'd0, 5'd0, 32'd1,          1'b0, 32'h0);
    add_vec(6'd60, 5'd1, 5'd0, 5'd0, 32'h00100000,   1'b0, 32'h0);
    add_vec(6'd61, 5'd1, 5'd2, 5'd0, 32'd0,          1'b1, 32'h000100E7);
    add_vec(6'd62, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 32'h0);
    add_vec(6'd63, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst in_ready",   {63'd0, in_ready},   64'd1);
    chk("rst out_valid",  {63'd0, out_valid},  64'd0);
    chk("rst out_data",   out_data,            64'd0);
    chk("rst out_half",   {63'd0, out_half},   64'd0);
    chk("rst err",        {63'd0, err},        64'd0);
    chk("rst err_cnt",    {48'd0, err_cnt},    64'd0);
    chk("rst pack_state", {63'd0, pack_state}, 64'd0);
    @(posedge clk); #1;

    // ADD then ADDI back-to-back: word appears two cycles after second accept.
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(6'd28, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("pair lat N+1 valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("pair lat N+2 valid", {63'd0, out_valid}, 64'd1);
    chk("pair lat data", out_data, 64'hFFF00293_003100B3);
    chk("pair lat half", {63'd0, out_half}, 64'd0);
    exp_q.push_back({1'b0, 64'hFFF00293_003100B3});
    idle(3);
    check_queues("pair");

    // Single ADD flushed with padding.
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    exp_q.push_back({1'b1, 64'h00000013_003100B3});
    idle(4);
    check_queues("flush");

    // SRAI + JAL pair.
    send(6'd36, 5'd1, 5'd1, 5'd0, 32'd63, 1'b0);
    send(6'd60, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    exp_q.push_back({1'b0, 64'h001000EF_43F0D093});
    idle(4);
    check_queues("srai_jal");

    // Three illegal requests.
    eb = err_seen;
    send(6'd52, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    send(6'd40, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0);
    send(6'd63, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    ill_total += 3;
    idle(4);
    chk("illegal err pulses", 64'(err_seen - eb), 64'd3);
    chk("illegal err_cnt", {48'd0, err_cnt}, 64'd3);
    check_queues("illegal");

    // Vector table, each entry flushed on its own.
    foreach (vecs[i]) begin
      eb = err_seen;
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1);
      if (vecs[i].legal) exp_q.push_back({1'b1, ENC_NOP, vecs[i].word});
      else ill_total++;
      idle(4);
      check_queues($sformatf("vec%0d op%0d", i, vecs[i].op));
      chk($sformatf("vec%0d err", i), 64'(err_seen - eb), vecs[i].legal ? 64'd0 : 64'd1);
    end
    chk("table err_cnt", {48'd0, err_cnt}, 64'(ill_total));

    // Backpressure: six requests offered, output stalled five cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send(6'(k), 5'(k + 1), 5'(k + 2), 5'(k + 3), 32'd0, 1'b0);
          model_accept(6'(k), 5'(k + 1), 5'(k + 2), 5'(k + 3), 32'd0, 1'b0);
        end
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("stall out_valid seen", {63'd0, seen}, 64'd1);
        held = out_data;
        for (int t = 0; t < 5; t++) begin
          if (t > 0) @(negedge clk);
          chk("stall in_ready", {63'd0, in_ready}, 64'd0);
          chk("stall out_valid", {63'd0, out_valid}, 64'd1);
          chk("stall data held", out_data, held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    check_queues("stall");

    // Randomized traffic against the reference model.
    m_ill = 0;
    eb = err_seen;
    rnd_on = 1'b1;
    fork
      begin
        logic [31:0] imm;
        for (int k = 0; k < 300; k++) begin
          logic [5:0] op;
          logic [4:0] rd, rs1, rs2;
          logic       last;
          op  = 6'($urandom_range(0, 63));
          rd  = 5'($urandom_range(0, 31));
          rs1 = 5'($urandom_range(0, 31));
          rs2 = 5'($urandom_range(0, 31));
          case ($urandom_range(0, 5))
            0: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
            1: imm = $urandom();
            2: imm = 32'($urandom_range(0, 70));
            3: imm = $urandom() & 32'hFFFFF000;
            4: imm = 32'($urandom_range(0, 9000)) - 32'd4500;
            default: imm = 32'($urandom_range(0, 4200000)) - 32'd2100000;
          endcase
          last = ($urandom_range(0, 7) == 0);
          send(op, rd, rs1, rs2, imm, last);
          model_accept(op, rd, rs1, rs2, imm, last);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    model_accept(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    idle(6);
    check_queues("random");
    chk("random err pulses", 64'(err_seen - eb), 64'(m_ill));
    chk("random err_cnt", {48'd0, err_cnt}, 64'(ill_total));

    // Reset while holding a half word discards it.
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    idle(2);
    chk("half before reset", {63'd0, pack_state}, 64'd1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_pend = 1'b0;
    ill_total = 0;
    got_q.delete();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("post reset out_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("post reset pack_state", {63'd0, pack_state}, 64'd0);
    chk("post reset err_cnt", {48'd0, err_cnt}, 64'd0);
    @(posedge clk); #1;
    send(6'd9, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    model_accept(6'd9, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    send(6'd33, 5'd7, 5'd8, 5'd0, 32'd255, 1'b0);
    model_accept(6'd33, 5'd7, 5'd8, 5'd0, 32'd255, 1'b0);
    idle(4);
    check_queues("after reset pair");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
